// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter in front of a single fifo, with a per-tenure burst lock.
// Optional FIFO_ARB_STALL_CNT_EN adds a saturating stall_cnt output.
module fifo_push_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 2,
    parameter int BURST = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       grant,
    input  logic                   cons_pop,
    input  logic                   fifo_full,
    output logic                   fifo_push,
    output logic                   fifo_pop,
    output logic [WIDTH-1:0]       fifo_in
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [3:0]    cnt;
    logic [PW-1:0] win;
    logic          found;
    logic          can_push;
    logic          take;
    logic [4:0]    n;
    int            idx;

    assign can_push = !fifo_full || cons_pop;

    // Rotating search starting at ptr; first requester found wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // Outputs are held at zero for the whole time reset is asserted.
    assign take      = reset && found && can_push;
    assign grant     = take ? (N_REQ'(1) << win) : '0;
    assign fifo_push = take;
    assign fifo_pop  = reset && cons_pop;
    assign fifo_in   = take ? req_data[win*WIDTH +: WIDTH] : '0;

    // A new owner (win != ptr) starts its tenure at 1.
    assign n = ((win == ptr) ? {1'b0, cnt} : 5'd0) + 5'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (take) begin
            if (n == 5'(BURST)) begin
                ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
                cnt <= '0;
            end else begin
                ptr <= win;
                cnt <= n[3:0];
            end
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (|req && !can_push && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench: a BURST=1 and a BURST=2 arbiter share one stimulus stream.
module tb_fifo_push_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [7:0] req_data;
    logic       cons_pop;
    logic       fifo_full;

    logic [3:0] g1, g2;
    logic       push1, push2, pop1, pop2;
    logic [1:0] in1, in2;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] sc1, sc2;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fifo_push_arbiter #(.N_REQ(4), .WIDTH(2), .BURST(1)) u_b1 (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(g1),
        .cons_pop(cons_pop), .fifo_full(fifo_full), .fifo_push(push1),
        .fifo_pop(pop1), .fifo_in(in1)
`ifdef FIFO_ARB_STALL_CNT_EN
        , .stall_cnt(sc1)
`endif
    );

    fifo_push_arbiter #(.N_REQ(4), .WIDTH(2), .BURST(2)) u_b2 (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(g2),
        .cons_pop(cons_pop), .fifo_full(fifo_full), .fifo_push(push2),
        .fifo_pop(pop2), .fifo_in(in2)
`ifdef FIFO_ARB_STALL_CNT_EN
        , .stall_cnt(sc2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        req       = 4'b1111;
        req_data  = {2'b00, 2'b10, 2'b11, 2'b01};
        cons_pop  = 1'b1;
        fifo_full = 1'b0;

        // Reset holds every output low even with requests and pop present
        step(); step();
        chk("rst_grant", g1, 4'b0000);
        chk("rst_push", push1, 1'b0);
        chk("rst_pop", pop1, 1'b0);
        chk("rst_in", in1, 2'b00);

        // 1: pure round-robin over all four
        reset = 1'b1; cons_pop = 1'b0;
        #1;
        chk("rr_g0", g1, 4'b0001); chk("rr_d0", in1, 2'b01);
        step(); #1;
        chk("rr_g1", g1, 4'b0010); chk("rr_d1", in1, 2'b11);
        step(); #1;
        chk("rr_g2", g1, 4'b0100); chk("rr_d2", in1, 2'b10);
        step(); #1;
        chk("rr_g3", g1, 4'b1000); chk("rr_d3", in1, 2'b00);
        step(); #1;
        chk("rr_wrap", g1, 4'b0001); chk("rr_wrap_d", in1, 2'b01);

        // 2: two requesters alternate
        step();
        req = 4'b1010; req_data = {2'b01, 2'b10, 2'b11, 2'b01};
        #1;
        chk("alt_g0", g1, 4'b0010); chk("alt_d0", in1, 2'b11); chk("alt_p0", push1, 1'b1);
        step(); #1;
        chk("alt_g1", g1, 4'b1000); chk("alt_d1", in1, 2'b01); chk("alt_p1", push1, 1'b1);
        step(); #1;
        chk("alt_g2", g1, 4'b0010); chk("alt_d2", in1, 2'b11);
        step(); #1;
        chk("alt_g3", g1, 4'b1000); chk("alt_d3", in1, 2'b01);

        // 3: stall on full without pop, then pop unblocks the push
        step();
        req = 4'b0100; fifo_full = 1'b1; cons_pop = 1'b0;
        #1;
        chk("stall_g0", g1, 4'b0000); chk("stall_p0", push1, 1'b0);
        step(); #1;
        chk("stall_g1", g1, 4'b0000);
        step(); #1;
        chk("stall_g2", g1, 4'b0000); chk("stall_p2", push1, 1'b0);
        step();
        cons_pop = 1'b1;
        #1;
        chk("fullpop_g", g1, 4'b0100);
        chk("fullpop_push", push1, 1'b1);
        chk("fullpop_pop", pop1, 1'b1);
        chk("fullpop_in", in1, 2'b10);
`ifdef FIFO_ARB_STALL_CNT_EN
        chk("stall_cnt", sc1, 16'd3);
`endif
        // ptr was 0 through the stall; granting r2 moves it to 3
        step();
        req = 4'b1111; fifo_full = 1'b0; cons_pop = 1'b0;
        #1;
        chk("after_stall_g", g1, 4'b1000);

        // 6: no requests, pop passes straight through
        step();
        req = 4'b0000; cons_pop = 1'b1;
        #1;
        chk("idle_g", g1, 4'b0000); chk("idle_push", push1, 1'b0);
        chk("idle_pop1", pop1, 1'b1); chk("idle_in", in1, 2'b00);
        step(); cons_pop = 1'b0; #1;
        chk("idle_pop0", pop1, 1'b0);
        step(); cons_pop = 1'b1; #1;
        chk("idle_pop1b", pop1, 1'b1);

        // 4: BURST=2 locking, then owner drops mid-burst
        step();
        reset = 1'b0; req = 4'b0011; cons_pop = 1'b0;
        req_data = {2'b00, 2'b10, 2'b11, 2'b01};
        #1;
        chk("b2_rst_g", g2, 4'b0000); chk("b2_rst_in", in2, 2'b00);
        reset = 1'b1;
        #1;
        chk("b2_g0", g2, 4'b0001);
        step(); #1;
        chk("b2_g1", g2, 4'b0001);
        step(); #1;
        chk("b2_g2", g2, 4'b0010); chk("b2_d2", in2, 2'b11);
        step(); #1;
        chk("b2_g3", g2, 4'b0010);
        step(); #1;
        chk("b2_g4", g2, 4'b0001);
        step();
        req = 4'b0010;
        #1;
        chk("b2_drop", g2, 4'b0010);

        // 5: reach ptr=2,cnt=1 then reset mid-burst
        step();
        req = 4'b0100;
        #1;
        chk("b2_r2a", g2, 4'b0100);
        step();
        reset = 1'b0; req = 4'b1100; cons_pop = 1'b1;
        #1;
        chk("mid_rst_g", g2, 4'b0000); chk("mid_rst_push", push2, 1'b0);
        chk("mid_rst_pop", pop2, 1'b0); chk("mid_rst_in", in2, 2'b00);
        reset = 1'b1; cons_pop = 1'b0;
        #1;
        chk("post_rst_g0", g2, 4'b0100);
        // cleared cnt means r2 keeps the lock for one more push
        step(); #1;
        chk("post_rst_g1", g2, 4'b0100);
        step(); #1;
        chk("post_rst_g2", g2, 4'b1000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Round-robin arbiter that shares the push port of one fifo instance among N_REQ producers.
- Each cycle it grants at most one requester and drives that requester's data onto fifo.in with fifo.push asserted.
- Honours fifo.full backpressure and forwards the consumer's pop.
- Sits directly in front of the fifo; its outputs connect 1:1 to fifo in/push/pop.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 2, data width; must equal fifo WIDTH
BURST, 1, max consecutive accepted pushes per grant tenure (1..15)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester push request
req_data  in  N_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
grant  out  N_REQ  one-hot grant; write accepted this cycle
cons_pop  in  1  consumer pop request
fifo_full  in  1  fifo full flag
fifo_push  out  1  to fifo push
fifo_pop  out  1  to fifo pop (= cons_pop)
fifo_in  out  WIDTH  to fifo in (granted requester's data)

Behaviour:
- State:
  - ptr: search start index, range 0..N_REQ-1.
  - cnt: current burst count, 0..BURST-1.
- Reset:
  - While reset=0: ptr=0 and cnt=0, applied asynchronously.
  - While reset=0, grant, fifo_push, fifo_pop and fifo_in are forced to 0.
- Accept condition: can_push = !fifo_full || cons_pop.
  - Pushing while full is legal only together with a pop, matching fifo semantics.
- Grant selection (combinational, zero latency):
  - If |req and can_push, grant the first i with req[i]=1, searching ptr, ptr+1, ..., wrapping N_REQ-1 -> 0.
  - Otherwise grant=0.
- Output data path:
  - fifo_push = |grant.
  - fifo_in = req_data slice of the granted requester; 0 when no grant.
  - fifo_pop = cons_pop, passed through unconditionally; the fifo ignores pop when empty.
- Update on posedge, only when a grant is issued to requester r:
  - n = (r==ptr ? cnt : 0) + 1.
  - If n==BURST: ptr = (r+1) mod N_REQ, cnt = 0.
  - Else: ptr = r, cnt = n (r keeps priority).
- Hold conditions:
  - No grant (no requests, or stalled by full without pop): ptr and cnt hold, so the lock is preserved across the stall.
- Owner drops req mid-burst: the search starts at ptr=owner, owner is skipped, and the next requester in order wins the same cycle. Its tenure starts with n=1.
- BURST=1 degenerates to pure round-robin: ptr advances past every winner.
- Fairness: any continuously requesting requester is granted within (N_REQ-1)*BURST accepted pushes.
- Simultaneous grant and pop when full: both pass through; the fifo performs push and pop in the same cycle.
- Reset mid-burst: ptr and cnt clear immediately; the first grant after release searches from 0.

Optional Feature:
Macro FIFO_ARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - stall_cnt increments on each posedge where |req=1 and can_push=0.
  - It saturates at 16'hFFFF and clears on reset.
- Undefined: the port and counter are absent, and the remaining behaviour is identical.

Test Plan:
1. Reset=0, req=4'b1111, then release with fifo_full=0 (N_REQ=4, BURST=1) -> grant 0001, 0010, 0100, 1000, 0001 on successive cycles; fifo_in follows each requester's data.
2. req=4'b1010, req_data[1]=2'b11, req_data[3]=2'b01, fifo_full=0 -> grants alternate 0010/1000; fifo_in alternates 11/01; fifo_push=1 every cycle.
3. fifo_full=1, cons_pop=0, req=4'b0100 for 3 cycles -> grant=0, fifo_push=0, ptr unchanged. With the macro defined, stall_cnt=3. Then cons_pop=1 -> grant=0100 and fifo_push=fifo_pop=1 in the same cycle.
4. BURST=2, req=4'b0011 held -> grant 0001, 0001, 0010, 0010, 0001. Drop req[0] after its first grant -> next cycle grants 0010.
5. Assert reset=0 mid-burst (ptr=2, cnt=1), release with req=4'b1100 -> first grant 0100 (search from 0); all outputs 0 while reset is low.
6. req=0 with cons_pop toggling -> grant=0, fifo_push=0, and fifo_pop mirrors cons_pop each cycle.
